dimmer_pwm: RTL and testbench

DIMMER_PWM -- requirements
Module: dimmer_pwm

---
 rtl/dimmer_pkg.sv | 13 +
 rtl/pwm_gen.sv | 34 +++
 rtl/dimmer_pwm.sv | 123 ++++++++++++
 tb/tb_dimmer_pwm.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dimmer_pkg.sv
// Shared types and defaults for the LED dimmer: FSM state encoding and brightness width.
package dimmer_pkg;

    localparam int unsigned LEVEL_BITS_DEF = 8;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } state_e;

endpackage : dimmer_pkg

// File: rtl/pwm_gen.sv
// Free-running PWM counter and comparator producing a registered LED drive from a brightness level.
module pwm_gen
    import dimmer_pkg::*;
#(
    parameter int unsigned LEVEL_BITS = LEVEL_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEVEL_BITS-1:0] level,
    output logic                  pwm_out
);

    localparam logic [LEVEL_BITS-1:0] MAX_LEVEL = '1;

    logic [LEVEL_BITS-1:0] cnt_q;
    logic                  pwm_d;
    logic                  pwm_q;

    // Full scale forces a constant high; otherwise duty is level/2**LEVEL_BITS.
    assign pwm_d = (level == MAX_LEVEL) || (cnt_q < level);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + LEVEL_BITS'(1);
            pwm_q <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule : pwm_gen

// File: rtl/dimmer_pwm.sv
// LED dimmer: synchronises the lamp request, ramps brightness one level per STEP_CYCLES and drives PWM.
module dimmer_pwm
    import dimmer_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 4,
    parameter int unsigned LEVEL_BITS  = LEVEL_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  saida,
    output logic                  pwm_out,
    output logic [LEVEL_BITS-1:0] level,
    output logic                  busy,
    output logic                  ramp_done
);

    localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [LEVEL_BITS-1:0] MAX_LEVEL = '1;
    localparam logic [CNT_W-1:0]      STEP_LAST = CNT_W'(STEP_CYCLES - 1);

    state_e                state_q, state_d;
    logic [LEVEL_BITS-1:0] level_q, level_d;
    logic [CNT_W-1:0]      step_q, step_d;
    logic                  sync1_q, req_s_q;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  step_hit;

    // Two-flop synchroniser for the asynchronous lamp request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            req_s_q <= 1'b0;
        end else begin
            sync1_q <= saida;
            req_s_q <= sync1_q;
        end
    end

    assign step_hit = (step_q == STEP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= OFF;
            level_q <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state: a reversal takes priority over a step landing on the same cycle.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        step_d  = step_q;
        done_d  = 1'b0;
        case (state_q)
            OFF: begin
                level_d = '0;
                step_d  = '0;
                if (req_s_q) state_d = RAMP_UP;
            end
            RAMP_UP: begin
                if (!req_s_q) begin
                    state_d = RAMP_DOWN;
                    step_d  = '0;
                end else if (step_hit) begin
                    step_d = '0;
                    if (level_q != MAX_LEVEL) level_d = level_q + LEVEL_BITS'(1);
                    if (level_q >= MAX_LEVEL - LEVEL_BITS'(1)) begin
                        state_d = ON;
                        done_d  = 1'b1;
                    end
                end else begin
                    step_d = step_q + CNT_W'(1);
                end
            end
            ON: begin
                level_d = MAX_LEVEL;
                step_d  = '0;
                if (!req_s_q) state_d = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (req_s_q) begin
                    state_d = RAMP_UP;
                    step_d  = '0;
                end else if (step_hit) begin
                    step_d = '0;
                    if (level_q != '0) level_d = level_q - LEVEL_BITS'(1);
                    if (level_q <= LEVEL_BITS'(1)) begin
                        state_d = OFF;
                        done_d  = 1'b1;
                    end
                end else begin
                    step_d = step_q + CNT_W'(1);
                end
            end
            default: state_d = OFF;
        endcase
        busy_d = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
    end

    pwm_gen #(
        .LEVEL_BITS(LEVEL_BITS)
    ) u_pwm_gen (
        .clk     (clk),
        .rst     (rst),
        .level   (level_q),
        .pwm_out (pwm_out)
    );

    assign level     = level_q;
    assign busy      = busy_q;
    assign ramp_done = done_q;

endmodule : dimmer_pwm

// File: tb/tb_dimmer_pwm.sv
// Bench for dimmer_pwm: cycle-level brightness model plus directed ramp, reversal, duty and reset scenarios.
module tb_dimmer_pwm;

    localparam int STEP = 4;
    localparam int LB   = 8;
    localparam int MAXL = (1 << LB) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          saida;
    logic          pwm_out;
    logic [LB-1:0] level;
    logic          busy;
    logic          ramp_done;

    int total = 0;
    int bad   = 0;

    dimmer_pwm #(
        .STEP_CYCLES(STEP),
        .LEVEL_BITS (LB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .saida     (saida),
        .pwm_out   (pwm_out),
        .level     (level),
        .busy      (busy),
        .ramp_done (ramp_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: direction of travel (+1 up, -1 down, 0 parked) and brightness as plain integers.
    int m_s1, m_s2, m_dir, m_lvl, m_tick, m_done, m_pwm, m_cnt;

    always @(posedge clk or negedge rst) begin
        int req, n_lvl, n_dir, n_tick, n_done;
        if (!rst) begin
            m_s1 = 0; m_s2 = 0; m_dir = 0; m_lvl = 0;
            m_tick = 0; m_done = 0; m_pwm = 0; m_cnt = 0;
        end else begin
            req    = m_s2;
            n_lvl  = m_lvl;
            n_dir  = m_dir;
            n_tick = m_tick;
            n_done = 0;
            if (m_dir == 0) begin
                n_tick = 0;
                if (m_lvl == 0 && req == 1) n_dir = 1;
                else if (m_lvl == MAXL && req == 0) n_dir = -1;
            end else if ((m_dir == 1) != (req == 1)) begin
                n_dir  = -m_dir;
                n_tick = 0;
            end else if (m_tick == STEP - 1) begin
                n_tick = 0;
                n_lvl  = m_lvl + m_dir;
                if (n_lvl > MAXL) n_lvl = MAXL;
                if (n_lvl < 0)    n_lvl = 0;
                if (n_lvl == 0 || n_lvl == MAXL) begin
                    n_dir  = 0;
                    n_done = 1;
                end
            end else begin
                n_tick = m_tick + 1;
            end
            m_pwm  = (m_lvl == MAXL || m_cnt < m_lvl) ? 1 : 0;
            m_cnt  = (m_cnt + 1) % (MAXL + 1);
            m_lvl  = n_lvl;
            m_dir  = n_dir;
            m_tick = n_tick;
            m_done = n_done;
            m_s2   = m_s1;
            m_s1   = int'(saida);
        end
    end

    // Every cycle out of reset, the DUT must match the model.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("model_level", int'(level), m_lvl);
            check("model_busy", int'(busy), (m_dir != 0) ? 1 : 0);
            check("model_done", int'(ramp_done), m_done);
            check("model_pwm", int'(pwm_out), m_pwm);
        end
    end

    int n, cnt_a, cnt_b, first_n, first_lvl;

    initial begin
        rst   = 1'b0;
        saida = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_level", int'(level), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(ramp_done), 0);
        check("rst_pwm", int'(pwm_out), 0);
        rst = 1'b1;

        // Idle with the lamp off.
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cnt_a += int'(ramp_done);
            cnt_b += int'(busy) + int'(pwm_out) + int'(level != 0);
        end
        check("idle_done_pulses", cnt_a, 0);
        check("idle_activity", cnt_b, 0);

        // Full ramp up.
        saida = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk); n++;
            if (busy) break;
        end
        check("busy_rise_cycle", n, 3);
        n = 0; cnt_a = 0;
        while (n < 2000) begin
            @(negedge clk); n++;
            cnt_a += int'(ramp_done);
            if (ramp_done) break;
        end
        check("up_ramp_len", n, 1020);
        check("up_level", int'(level), 255);
        check("up_busy_at_done", int'(busy), 0);
        check("up_done_pulses", cnt_a, 1);

        // Full brightness: constant drive, no further pulses.
        repeat (2) @(negedge clk);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            cnt_a += int'(pwm_out);
            cnt_b += int'(ramp_done);
        end
        check("on_pwm_high", cnt_a, 256);
        check("on_done_pulses", cnt_b, 0);

        // Full ramp down.
        saida = 1'b0;
        n = 0; first_n = 0; first_lvl = -1;
        while (n < 2000) begin
            @(negedge clk); n++;
            if (first_n == 0 && level != 8'd255) begin
                first_n = n; first_lvl = int'(level);
            end
            if (ramp_done) break;
        end
        check("down_first_step_cycle", first_n, 7);
        check("down_first_step_level", first_lvl, 254);
        check("down_ramp_len", n, 1023);
        check("down_level", int'(level), 0);
        repeat (2) @(negedge clk);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            cnt_a += int'(pwm_out);
            cnt_b += int'(busy);
        end
        check("off_pwm_high", cnt_a, 0);
        check("off_busy", cnt_b, 0);

        // Reversal at level 100 while ramping up.
        saida = 1'b1;
        n = 0;
        while (n < 2000 && level != 8'd100) begin
            @(negedge clk); n++;
        end
        check("reach_100", int'(level), 100);
        saida = 1'b0;
        n = 0;
        while (n < 20 && level == 8'd100) begin
            @(negedge clk); n++;
        end
        check("rev_step_cycle", n, 7);
        check("rev_step_level", int'(level), 99);
        n = 0; cnt_a = 0;
        while (n < 1000) begin
            @(negedge clk); n++;
            if (ramp_done) break;
            cnt_a += int'(level > 8'd99);
        end
        check("rev_done_cycle", n, 396);
        check("rev_done_level", int'(level), 0);
        check("rev_no_jump", cnt_a, 0);

        // Freeze level at 64 with reversals faster than a step, then measure duty.
        saida = 1'b1;
        n = 0;
        while (n < 2000 && level != 8'd64) begin
            @(negedge clk); n++;
        end
        check("reach_64", int'(level), 64);
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) saida = ~saida;
            @(negedge clk);
        end
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 256; i++) begin
            if (i % 2 == 0) saida = ~saida;
            @(negedge clk);
            cnt_a += int'(pwm_out);
            cnt_b += int'(level != 8'd64);
        end
        check("duty_64", cnt_a, 64);
        check("hold_64", cnt_b, 0);

        // Asynchronous reset mid-ramp, then restart from zero.
        saida = 1'b1;
        n = 0;
        while (n < 2000 && level != 8'd128) begin
            @(negedge clk); n++;
        end
        check("reach_128", int'(level), 128);
        #2 rst = 1'b0;
        #1;
        check("async_level", int'(level), 0);
        check("async_busy", int'(busy), 0);
        check("async_done", int'(ramp_done), 0);
        check("async_pwm", int'(pwm_out), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n = 0; cnt_a = 0;
        while (n < 2000) begin
            @(negedge clk); n++;
            if (n == 1) check("restart_level0", int'(level), 0);
            if (ramp_done) break;
        end
        check("restart_len", n, 1023);
        check("restart_level", int'(level), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dimmer_pwm
